// File: rtl/i2c_tx_engine.sv
// i2c_tx_engine
//   Master-side I2C write engine. For each accepted request it emits START,
//   the 7-bit address with W=0, checks the ACK, sends byte_count data bytes
//   drained from the show-ahead TX FIFO (each followed by an ACK check),
//   then emits STOP and pulses done.
//
// Parameters
//   CLK_DIV    clk cycles per SCL quarter-period (2..4095); SCL = 4*CLK_DIV
//
// Optional feature
//   I2C_CLK_STRETCH_EN  when defined, the quarter counter holds in Q2 of
//                       every bit cell and in STOP Q1 while scl_in is low, so a
//                       target can stretch the clock. When undefined, scl_in is
//                       ignored and the bus timing is fixed.
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   start_request               one-cycle pulse, accepted only while idle
//   address, byte_count         sampled on the accepting edge (0 = probe)
//   fifo_rd_data/_empty/_index  FIFO head byte, empty flag, read pointer
//   fifo_rd_request             pop request, held until the read pointer moves
//   sda_in, scl_in              synchronized pin levels
//   sda_oe, scl_oe              1 = pull the line low, 0 = release
//   busy, done                  transaction in flight / one-cycle end pulse
//   nack_error, underflow       sticky status, cleared by clear_error_request
//   dbg_state                   current FSM state (IDLE=0 ... DONE=8)
//
// Handshake: fifo_rd_request is a level request. The pop is complete once
// fifo_rd_index differs from the value captured with the head byte; until
// then the request stays high (the FIFO may defer the pop for a write).
module i2c_tx_engine #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_request,
    input  logic [6:0] address,
    input  logic [4:0] byte_count,
    input  logic [7:0] fifo_rd_data,
    input  logic       fifo_empty,
    input  logic [3:0] fifo_rd_index,
    output logic       fifo_rd_request,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic       busy,
    output logic       done,
    output logic       nack_error,
    output logic       underflow,
    input  logic       clear_error_request,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ACK_A, S_LOAD, S_DATA, S_ACK_D, S_STOP, S_DONE
    } state_e;

    localparam logic [11:0] CNT_LAST = 12'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;     // clk cycles within the current quarter
    logic [1:0]  qtr_q, qtr_d;     // quarter within the current cell
    logic [2:0]  bit_q, bit_d;     // bit cell within ADDR / DATA
    logic [7:0]  shift_q, shift_d;
    logic [4:0]  rem_q, rem_d;     // data bytes still to be loaded
    logic        ack_q, ack_d;     // sampled SDA of the ACK cell (1 = NACK)
    logic [3:0]  idx_q, idx_d;     // read pointer seen when the byte was captured
    logic        wait_q, wait_d;   // LOAD: byte captured, waiting for the pop
    logic        nack_q, nack_d;
    logic        udf_q, udf_d;

    logic bit_state, timed_state, hold, q_end, cell_end;

    assign bit_state   = (state_q == S_ADDR) || (state_q == S_ACK_A) ||
                         (state_q == S_DATA) || (state_q == S_ACK_D);
    assign timed_state = bit_state || (state_q == S_START) || (state_q == S_STOP);

`ifdef I2C_CLK_STRETCH_EN
    // Freeze only in the quarters where SCL has been released by us, so a
    // low scl_in there can only mean the target is stretching.
    assign hold = !scl_in && ((bit_state && qtr_q == 2'd2) ||
                              (state_q == S_STOP && qtr_q == 2'd1));
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold = 1'b0;
`endif

    assign q_end    = timed_state && (cnt_q == CNT_LAST) && !hold;
    assign cell_end = q_end && (qtr_q == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            qtr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rem_q   <= '0;
            ack_q   <= 1'b0;
            idx_q   <= '0;
            wait_q  <= 1'b0;
            nack_q  <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
            ack_q   <= ack_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            nack_q  <= nack_d;
            udf_q   <= udf_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        qtr_d           = qtr_q;
        bit_d           = bit_q;
        shift_d         = shift_q;
        rem_d           = rem_q;
        ack_d           = ack_q;
        idx_d           = idx_q;
        wait_d          = wait_q;
        nack_d          = nack_q;
        udf_d           = udf_q;
        scl_oe          = 1'b0;
        sda_oe          = 1'b0;
        fifo_rd_request = 1'b0;
        done            = 1'b0;

        // Clear first so that a set in the same cycle below takes priority.
        if (clear_error_request) begin
            nack_d = 1'b0;
            udf_d  = 1'b0;
        end

        if (timed_state && !hold) begin
            cnt_d = q_end ? 12'd0 : cnt_q + 12'd1;
        end
        if (q_end) begin
            qtr_d = qtr_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_request) begin
                    state_d = S_START;
                    rem_d   = byte_count;
                    shift_d = {address, 1'b0};
                end
            end
            S_START: begin
                sda_oe = qtr_q[1];
                if (cell_end) state_d = S_ADDR;
            end
            S_ADDR, S_DATA: begin
                scl_oe = !qtr_q[1];
                sda_oe = !shift_q[7];
                if (cell_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = (state_q == S_ADDR) ? S_ACK_A : S_ACK_D;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
            end
            S_ACK_A, S_ACK_D: begin
                scl_oe = !qtr_q[1];
                if (q_end && qtr_q == 2'd2) ack_d = sda_in;
                if (cell_end) begin
                    if (ack_q) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else if (rem_q != 5'd0) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_STOP;
                    end
                end
            end
            S_LOAD: begin
                scl_oe = 1'b1;
                if (!wait_q) begin
                    if (fifo_empty) begin
                        udf_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d         = fifo_rd_data;
                        idx_d           = fifo_rd_index;
                        wait_d          = 1'b1;
                        fifo_rd_request = 1'b1;
                    end
                end else if (fifo_rd_index == idx_q) begin
                    fifo_rd_request = 1'b1;
                end else begin
                    wait_d  = 1'b0;
                    rem_d   = rem_q - 5'd1;
                    state_d = S_DATA;
                end
            end
            S_STOP: begin
                scl_oe = (qtr_q == 2'd0);
                sda_oe = !qtr_q[1];
                if (cell_end) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Every state starts with a fresh quarter counter and bit index.
        if (state_d != state_q) begin
            cnt_d = '0;
            qtr_d = '0;
            bit_d = '0;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign nack_error = nack_q;
    assign underflow  = udf_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_i2c_tx_engine.sv
// Bench for i2c_tx_engine: FIFO model, bus-level target/decoder, table of
// transactions plus hand-written corner sequences.
module tb_i2c_tx_engine;

    localparam int D = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_request = 1'b0;
    logic [6:0] address = '0;
    logic [4:0] byte_count = '0;
    logic [7:0] fifo_rd_data;
    logic       fifo_empty;
    logic [3:0] fifo_rd_index;
    logic       fifo_rd_request;
    logic       sda_in, scl_in, sda_oe, scl_oe;
    logic       busy, done, nack_error, underflow;
    logic       clear_error_request = 1'b0;
    logic [3:0] dbg_state;

    logic tgt_pull = 1'b0;   // target pulls SDA low
    logic stretch  = 1'b0;   // target holds SCL low
    logic block_pop = 1'b0;  // FIFO favours a concurrent write

    assign sda_in = !sda_oe && !tgt_pull;
    assign scl_in = !scl_oe && !stretch;

    i2c_tx_engine #(.CLK_DIV(D)) dut (
        .clk(clk), .reset(reset), .start_request(start_request),
        .address(address), .byte_count(byte_count),
        .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .fifo_rd_index(fifo_rd_index), .fifo_rd_request(fifo_rd_request),
        .sda_in(sda_in), .scl_in(scl_in), .sda_oe(sda_oe), .scl_oe(scl_oe),
        .busy(busy), .done(done), .nack_error(nack_error), .underflow(underflow),
        .clear_error_request(clear_error_request), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- FIFO model ----------------
    logic [7:0] fifo_mem [16];
    logic [4:0] wr_ptr = '0;
    logic [4:0] rd_ptr = '0;
    int         pop_cnt = 0;

    assign fifo_empty    = (wr_ptr == rd_ptr);
    assign fifo_rd_index = rd_ptr[3:0];
    assign fifo_rd_data  = fifo_mem[rd_ptr[3:0]];

    always @(posedge clk) begin
        if (fifo_rd_request && !fifo_empty && !block_pop) begin
            rd_ptr  <= rd_ptr + 5'd1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    task automatic fifo_push(input logic [7:0] b);
        fifo_mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    // ---------------- bus decoder / target ----------------
    int         nack_at = -1;     // byte index (0 = address) the target NACKs
    int         start_cnt = 0, stop_cnt = 0, rx_cnt = 0;
    logic [7:0] rx_mem [64];

    initial begin : decoder
        logic       prev_scl, prev_sda, scl_now, sda_now;
        logic [7:0] rx_sh;
        int         bit_cnt, byte_idx;
        prev_scl = 1'b1; prev_sda = 1'b1; rx_sh = '0; bit_cnt = 0; byte_idx = 0;
        forever begin
            @(negedge clk);
            scl_now = !scl_oe;
            sda_now = !sda_oe && !tgt_pull;
            if (scl_now && prev_scl && prev_sda && !sda_now) begin
                start_cnt = start_cnt + 1;
                bit_cnt = 0;
                byte_idx = 0;
            end else if (scl_now && prev_scl && !prev_sda && sda_now) begin
                stop_cnt = stop_cnt + 1;
            end else if (scl_now && !prev_scl) begin
                if (bit_cnt < 8) rx_sh = {rx_sh[6:0], sda_now};
                bit_cnt = bit_cnt + 1;
            end else if (!scl_now && prev_scl) begin
                if (bit_cnt == 8) begin
                    rx_mem[rx_cnt % 64] = rx_sh;
                    rx_cnt = rx_cnt + 1;
                    tgt_pull = (byte_idx != nack_at);
                    byte_idx = byte_idx + 1;
                end else if (bit_cnt == 9) begin
                    tgt_pull = 1'b0;
                    bit_cnt = 0;
                end
            end
            prev_scl = scl_now;
            prev_sda = !sda_oe && !tgt_pull;
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int total = 0, bad = 0, rx_rd = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drain_rx();
        while (rx_rd < rx_cnt) begin
            if (exp_q.size() == 0) begin
                check("extra_byte", 32'(rx_mem[rx_rd % 64]), 32'hFFFF_FFFF);
            end else begin
                check("wire_byte", 32'(rx_mem[rx_rd % 64]), 32'(exp_q.pop_front()));
            end
            rx_rd = rx_rd + 1;
        end
        check("missing_bytes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic start_txn(input logic [6:0] a, input logic [4:0] n);
        address = a;
        byte_count = n;
        start_request = 1'b1;
        @(negedge clk);
        start_request = 1'b0;
        address = 7'($urandom_range(0, 127));
        byte_count = 5'($urandom_range(0, 31));
        check("busy_rise", 32'(busy), 32'd1);
    endtask

    // Counts edges from START entry to DONE entry; pulses an ignored
    // start_request at cycle 20 and optionally drives clear / stretch.
    task automatic wait_done(input int clr_until, input int st_from, input int st_to,
                             output int cyc);
        cyc = 0;
        if (clr_until >= 0) clear_error_request = 1'b1;
        while (!done && cyc < 4000) begin
            if (cyc == 20) start_request = 1'b1;
            if (cyc == 21) start_request = 1'b0;
            if (cyc == clr_until) clear_error_request = 1'b0;
            if (cyc == st_from) stretch = 1'b1;
            if (cyc == st_to) stretch = 1'b0;
            @(negedge clk);
            cyc = cyc + 1;
        end
        start_request = 1'b0;
        clear_error_request = 1'b0;
        stretch = 1'b0;
        if (!done) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL done_timeout: got no done within %0d cycles", cyc);
        end
    endtask

    task automatic finish_checks(input int p0, input int s0, input int t0, input int pops,
                                 input logic en, input logic eu);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_fall", 32'(busy), 32'd0);
        check("pops", 32'(pop_cnt - p0), 32'(pops));
        check("nack_error", 32'(nack_error), 32'(en));
        check("underflow", 32'(underflow), 32'(eu));
        check("start_cond", 32'(start_cnt - s0), 32'd1);
        check("stop_cond", 32'(stop_cnt - t0), 32'd1);
        drain_rx();
    endtask

    task automatic clear_flags();
        clear_error_request = 1'b1;
        @(negedge clk);
        clear_error_request = 1'b0;
        check("clear_flags", 32'({nack_error, underflow}), 32'd0);
    endtask

    // ---------------- test ----------------
    typedef struct {
        logic [6:0] addr;
        logic [4:0] bc;
        int         nfill;
        int         nack_at;
        int         sent;
        logic       exp_nack;
        logic       exp_udf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc, p0, s0, t0, exp_dur;
        logic [7:0] b;

        vecs[0] = '{7'h50, 5'd2, 2, -1, 2, 1'b0, 1'b0};
        vecs[1] = '{7'h3F, 5'd0, 0,  0, 0, 1'b1, 1'b0};
        vecs[2] = '{7'h12, 5'd3, 1, -1, 1, 1'b0, 1'b1};
        vecs[3] = '{7'h7F, 5'd5, 5, -1, 5, 1'b0, 1'b0};
        vecs[4] = '{7'h2A, 5'd3, 2,  2, 2, 1'b1, 1'b0};
        vecs[5] = '{7'h00, 5'd1, 1, -1, 1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_scl_oe", 32'(scl_oe), 32'd0);
        check("rst_flags", 32'({busy, done, nack_error, underflow, fifo_rd_request}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table of complete transactions.
        for (int i = 0; i < 6; i++) begin
            nack_at = vecs[i].nack_at;
            exp_q.push_back({vecs[i].addr, 1'b0});
            for (int k = 0; k < vecs[i].nfill; k++) begin
                if (i == 0) b = (k == 0) ? 8'hA5 : 8'h3C;
                else        b = 8'($urandom_range(0, 255));
                fifo_push(b);
                if (k < vecs[i].sent) exp_q.push_back(b);
            end
            p0 = pop_cnt; s0 = start_cnt; t0 = stop_cnt;
            // Each completed LOAD costs 2 clk (capture, pop seen); an
            // underflow LOAD costs 1.
            exp_dur = (8 + 36 * (1 + vecs[i].sent)) * D + 2 * vecs[i].sent +
                      (vecs[i].exp_udf ? 1 : 0);
            start_txn(vecs[i].addr, vecs[i].bc);
            wait_done(-1, -1, -1, cyc);
            check("duration", 32'(cyc), 32'(exp_dur));
            finish_checks(p0, s0, t0, vecs[i].sent, vecs[i].exp_nack, vecs[i].exp_udf);
            clear_flags();
        end

        // Pop deferred by a concurrent FIFO write.
        nack_at = -1;
        block_pop = 1'b1;
        fifo_push(8'h96);
        exp_q.push_back({7'h21, 1'b0});
        exp_q.push_back(8'h96);
        p0 = pop_cnt; s0 = start_cnt; t0 = stop_cnt;
        start_txn(7'h21, 5'd1);
        cyc = 0;
        while (!fifo_rd_request && cyc < 500) begin
            @(negedge clk);
            cyc = cyc + 1;
        end
        check("rdreq_seen", 32'(fifo_rd_request), 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rdreq_held", 32'(fifo_rd_request), 32'd1);
            check("scl_low_load", 32'(scl_oe), 32'd1);
            check("no_pop_yet", 32'(pop_cnt - p0), 32'd0);
        end
        block_pop = 1'b0;
        @(negedge clk);
        check("rdreq_drop", 32'(fifo_rd_request), 32'd0);
        check("scl_low_after_pop", 32'(scl_oe), 32'd1);
        check("one_pop", 32'(pop_cnt - p0), 32'd1);
        wait_done(-1, -1, -1, cyc);
        finish_checks(p0, s0, t0, 1, 1'b0, 1'b0);

        // NACK probe with clear held through the edge that sets the flag.
        nack_at = 0;
        exp_q.push_back({7'h3F, 1'b0});
        p0 = pop_cnt; s0 = start_cnt; t0 = stop_cnt;
        start_txn(7'h3F, 5'd0);
        wait_done(80, -1, -1, cyc);
        check("probe_duration", 32'(cyc), 32'(44 * D));
        finish_checks(p0, s0, t0, 0, 1'b1, 1'b0);

        // Reset in DATA bit 3 (nack_error is still set from the probe).
        nack_at = -1;
        fifo_push(8'hC3);
        exp_q.push_back({7'h55, 1'b0});
        start_txn(7'h55, 5'd1);
        repeat (109) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_sda", 32'(sda_oe), 32'd0);
        check("mid_rst_scl", 32'(scl_oe), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_flags", 32'({nack_error, underflow}), 32'd0);
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) cyc = cyc + 1;
        end
        check("no_done_after_rst", 32'(cyc), 32'd0);
        drain_rx();

        // Normal transaction after the reset.
        fifo_push(8'h5A);
        exp_q.push_back({7'h33, 1'b0});
        exp_q.push_back(8'h5A);
        p0 = pop_cnt; s0 = start_cnt; t0 = stop_cnt;
        start_txn(7'h33, 5'd1);
        wait_done(-1, -1, -1, cyc);
        check("post_rst_duration", 32'(cyc), 32'((8 + 72) * D + 2));
        finish_checks(p0, s0, t0, 1, 1'b0, 1'b0);

        // Target holds SCL low for 20 cycles from Q2 of address bit 5.
        exp_q.push_back({7'h0A, 1'b0});
        p0 = pop_cnt; s0 = start_cnt; t0 = stop_cnt;
        start_txn(7'h0A, 5'd0);
        wait_done(-1, 52, 72, cyc);
`ifdef I2C_CLK_STRETCH_EN
        check("stretch_duration", 32'(cyc), 32'(44 * D + 20));
`else
        check("stretch_duration", 32'(cyc), 32'(44 * D));
`endif
        finish_checks(p0, s0, t0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_tx_engine.md
# i2c_tx_engine

- Master-side I2C write engine: drains bytes from the TX `fifo` and serializes them onto an open-drain SDA/SCL pair.
- One transaction per request: START, 7-bit address with W=0, ACK check, `byte_count` data bytes each with ACK check, then STOP.
- Sits between the TX `fifo` read port and the pad drivers; status flags go to the peripheral register block.

## Interface
- CLK_DIV, 250, clk cycles per SCL quarter-period (SCL period = 4*CLK_DIV); legal 2..4095
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- start_request  input  1  one-cycle pulse; begins a transaction when idle
- address  input  7  target address, sampled on the accepting edge
- byte_count  input  5  data bytes to send, 0..31, sampled on the accepting edge; 0 = address-only probe
- fifo_rd_data  input  8  FIFO head byte (show-ahead, combinational)
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_index  input  4  FIFO read pointer, used to confirm pops
- fifo_rd_request  output  1  FIFO pop request
- sda_in  input  1  SDA pin level (synchronized upstream)
- scl_in  input  1  SCL pin level (synchronized upstream)
- sda_oe  output  1  1 = pull SDA low, 0 = release
- scl_oe  output  1  1 = pull SCL low, 0 = release
- busy  output  1  high from the accepting edge until `done`
- done  output  1  one-cycle pulse at transaction end, any outcome
- nack_error  output  1  sticky: a NACK was received
- underflow  output  1  sticky: FIFO was empty when a data byte was due
- clear_error_request  input  1  clears `nack_error` and `underflow`

## Operation
- Reset values: all outputs 0. State IDLE, SCL and SDA released.
- States:
  - IDLE -> START on `start_request`. `start_request` while busy is ignored.
  - START -> ADDR -> ACK_A.
  - ACK_A:
    - ACK: -> LOAD if the remaining count > 0, else -> STOP.
    - NACK: set `nack_error`, -> STOP.
  - LOAD -> DATA -> ACK_D.
  - ACK_D:
    - ACK and more bytes remain: -> LOAD.
    - Otherwise: -> STOP.
    - NACK: set `nack_error`, -> STOP.
  - STOP -> DONE -> IDLE.
- Shift order: ADDR shifts `{address, 1'b0}` MSB first. DATA shifts the captured byte MSB first.
- ACK bit: SDA is released. `sda_in`=0 is ACK, 1 is NACK.
- LOAD, FIFO empty: set `underflow`, -> STOP. No byte is popped.
- LOAD, FIFO not empty:
  - Capture `fifo_rd_data` into the shift register and capture `fifo_rd_index`.
  - Hold `fifo_rd_request` high until `fifo_rd_index` differs from the captured value, then drop it and -> DATA.
  - This covers cycles where the FIFO gives priority to a simultaneous write.
- SCL stays low for the whole LOAD state, however long it lasts.
- A sticky flag set and `clear_error_request` in the same cycle: the set wins.
- Reset mid-transaction:
  - Next edge releases SCL/SDA, returns to IDLE and clears all flags.
  - No STOP is generated and `done` does not pulse.

## Timing
- Quarter-tick counter: 0..CLK_DIV-1. A quarter ends when the counter wraps. The counter restarts at 0 on entry to every state.
- Bit cell (ADDR, DATA, ACK states), 4 quarters:
  - Q0, Q1: SCL low. SDA takes the bit value at the start of Q0.
  - Q2, Q3: SCL released.
  - `sda_in` is sampled on the Q2->Q3 boundary edge.
- START, 4 quarters:
  - Q0, Q1: SCL and SDA released.
  - Q2, Q3: SDA low, SCL released.
  - Exit with SCL pulled low.
- STOP, 4 quarters:
  - Q0: SDA low, SCL low.
  - Q1: SCL released.
  - Q2, Q3: SDA released.
- `start_request` at edge N: `busy`=1 and state START from N+1.
- DONE lasts one cycle with `done`=1. `busy` falls on the following edge.
- Duration, LOAD excluded: (8 + 36*(1+bytes_sent)) * CLK_DIV cycles from START entry to DONE entry.

## Configuration
- `I2C_CLK_STRETCH_EN` defined:
  - In Q2 of every bit cell and STOP Q1, the quarter counter holds while `scl_in`=0.
  - This lets a target stretch the clock.
- Not defined:
  - `scl_in` is ignored and timing is fixed.
  - The port remains present.

## Test plan
- CLK_DIV=2, address=7'h50, byte_count=2, FIFO holds 8'hA5, 8'h3C, target ACKs all -> SDA bit sequence 1010_0000 A 1010_0101 A 0011_1100 A framed by START/STOP; exactly 2 pops; `done` once; `nack_error`=0 and `underflow`=0.
- byte_count=0, address=7'h3F, target NACKs -> STOP right after the ACK_A cell; `nack_error`=1; no pop; `done` at cycle 44*CLK_DIV after START entry.
- byte_count=3, FIFO holds 1 byte -> one byte sent, then `underflow`=1 and STOP; `clear_error_request` pulse -> `underflow`=0.
- FIFO write asserted during the pop cycle (rd_index unchanged) -> `fifo_rd_request` stays high until the index advances; byte sent once; SCL low throughout.
- reset asserted in DATA bit 3 -> next edge `sda_oe`=`scl_oe`=`busy`=0; no `done`; a new `start_request` runs normally.
- With `I2C_CLK_STRETCH_EN`: hold `scl_in`=0 for 20 cycles in Q2 of address bit 5 -> transaction lengthens by exactly 20 cycles. Without the macro: no change in duration.
